// File: rtl/timed_ram_pkg.sv
// timed_ram_pkg: port FSM state encoding and lane-count helper shared by timed_ram and timed_port_fsm
package timed_ram_pkg;
  typedef enum logic {IDLE, WAIT} port_state_t;
  function automatic int lanes(input int word_size, input int lane_size);
    return word_size / lane_size;
  endfunction
endpackage

// File: rtl/timed_port_fsm.sv
// timed_port_fsm: one request/ready port with programmable wait states
//   abort/enable/req in; accept and complete are same-cycle strobes for the datapath; busy/rdy out
module timed_port_fsm
  import timed_ram_pkg::*;
#(
  parameter int WAIT_CYCLES = 0,
  parameter int DELAY_SIZE  = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic abort,
  input  logic enable,
  input  logic req,
  output logic accept,
  output logic complete,
  output logic busy,
  output logic rdy
);
  port_state_t state, state_n;
  logic [DELAY_SIZE-1:0] cnt, cnt_n;
  assign busy = state == WAIT;
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    complete = 1'b0;
    accept   = state == IDLE && req && enable && !abort;
    if (abort) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else if (accept) begin
      state_n = WAIT;
      cnt_n   = DELAY_SIZE'(WAIT_CYCLES);
    end else if (state == WAIT) begin
      if (cnt != '0) cnt_n = cnt - 1'b1;
      else begin
        complete = 1'b1;
        state_n  = IDLE;
      end
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      rdy   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      rdy   <= complete;
    end
  end
endmodule

// File: rtl/timed_ram.sv
// timed_ram: simple dual-port RAM with wait states, byte-lane writes and init sweep
//   init_start/init_done: re-init control; r_*: read port; w_*: write port (req/busy/rdy handshakes)
module timed_ram
  import timed_ram_pkg::*;
#(
  parameter int WORD_SIZE    = 16,
  parameter int LANE_SIZE    = 8,
  parameter int ADDRESS_SIZE = 4,
  parameter int MEMORY_QTY   = 16,
  parameter logic [WORD_SIZE-1:0] WORD_INIT = '0,
  parameter int READ_WAIT    = 0,
  parameter int WRITE_WAIT   = 0,
  parameter int DELAY_SIZE   = 4,
  parameter int READ_FIRST   = 0,
  localparam int LANES = lanes(WORD_SIZE, LANE_SIZE)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    init_start,
  output logic                    init_done,
  input  logic                    r_req,
  input  logic [ADDRESS_SIZE-1:0] r_addr,
  output logic                    r_busy,
  output logic                    r_rdy,
  output logic [WORD_SIZE-1:0]    r_data,
  input  logic                    w_req,
  input  logic [ADDRESS_SIZE-1:0] w_addr,
  input  logic [WORD_SIZE-1:0]    w_data,
  input  logic [LANES-1:0]        w_be,
  output logic                    w_busy,
  output logic                    w_rdy
);
  logic [WORD_SIZE-1:0] mem [MEMORY_QTY];
  logic sweeping, r_accept, r_complete, w_accept, w_complete, r_in, w_in, hit;
  logic [ADDRESS_SIZE-1:0] idx, ra, wa;
  logic [WORD_SIZE-1:0] wd, wmask, old, merged;
  logic [LANES-1:0] wbe;
  timed_port_fsm #(.WAIT_CYCLES(READ_WAIT), .DELAY_SIZE(DELAY_SIZE)) u_rd (
    .clock(clock), .reset_n(reset_n), .abort(init_start), .enable(init_done), .req(r_req),
    .accept(r_accept), .complete(r_complete), .busy(r_busy), .rdy(r_rdy));
  timed_port_fsm #(.WAIT_CYCLES(WRITE_WAIT), .DELAY_SIZE(DELAY_SIZE)) u_wr (
    .clock(clock), .reset_n(reset_n), .abort(init_start), .enable(init_done), .req(w_req),
    .accept(w_accept), .complete(w_complete), .busy(w_busy), .rdy(w_rdy));
  always_comb begin
    wmask = '0;
    for (int i = 0; i < LANES; i++) wmask[i*LANE_SIZE +: LANE_SIZE] = {LANE_SIZE{wbe[i]}};
    r_in   = int'(ra) < MEMORY_QTY;
    w_in   = int'(wa) < MEMORY_QTY;
    old    = r_in ? mem[ra] : WORD_INIT;
    // a write finishing on the same edge is forwarded into the read unless old data is wanted
    hit    = w_complete && w_in && r_in && ra == wa && READ_FIRST == 0;
    merged = hit ? (old & ~wmask) | (wd & wmask) : old;
  end
  // array has no reset: the sweep is what initialises contents
  always_ff @(posedge clock) begin
    if (sweeping) mem[idx] <= WORD_INIT;
    else if (w_complete && w_in) mem[wa] <= (mem[wa] & ~wmask) | (wd & wmask);
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sweeping  <= 1'b1;
      idx       <= ADDRESS_SIZE'(MEMORY_QTY - 1);
      init_done <= 1'b0;
      r_data    <= '0;
      ra        <= '0;
      wa        <= '0;
      wd        <= '0;
      wbe       <= '0;
    end else begin
      if (init_start) begin
        sweeping  <= 1'b1;
        idx       <= ADDRESS_SIZE'(MEMORY_QTY - 1);
        init_done <= 1'b0;
      end else if (sweeping) begin
        idx <= idx - 1'b1;
        if (idx == '0) begin
          sweeping  <= 1'b0;
          init_done <= 1'b1;
        end
      end
      if (r_accept) ra <= r_addr;
      if (w_accept) begin
        wa  <= w_addr;
        wd  <= w_data;
        wbe <= w_be;
      end
      if (r_complete) r_data <= merged;
    end
  end
endmodule

// File: tb/tb_timed_ram.sv
// tb_timed_ram: two configurations of timed_ram checked against an array model with random and directed traffic
module tb_timed_ram;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset_n = 1'b0;
  logic init_start [2];
  logic r_req [2];
  logic w_req [2];
  logic [3:0] r_addr [2];
  logic [3:0] w_addr [2];
  logic [15:0] w_data [2];
  logic [1:0] w_be [2];
  logic [1:0] init_done, r_busy, r_rdy, w_busy, w_rdy;
  logic [15:0] r_data [2];
  int qty [2] = '{16, 12};
  int rw [2] = '{1, 0};
  int ww [2] = '{2, 0};
  int rf [2] = '{0, 1};
  logic [15:0] ini [2] = '{16'h0000, 16'h5A5A};
  logic [15:0] model [2][16];
  int cyc = 0;
  int total = 0;
  int passes = 0;
  always @(posedge clock) cyc <= cyc + 1;

  timed_ram #(.READ_WAIT(1), .WRITE_WAIT(2), .READ_FIRST(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .init_start(init_start[0]), .init_done(init_done[0]),
    .r_req(r_req[0]), .r_addr(r_addr[0]), .r_busy(r_busy[0]), .r_rdy(r_rdy[0]), .r_data(r_data[0]),
    .w_req(w_req[0]), .w_addr(w_addr[0]), .w_data(w_data[0]), .w_be(w_be[0]),
    .w_busy(w_busy[0]), .w_rdy(w_rdy[0]));
  timed_ram #(.MEMORY_QTY(12), .WORD_INIT(16'h5A5A), .READ_WAIT(0), .WRITE_WAIT(0), .READ_FIRST(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .init_start(init_start[1]), .init_done(init_done[1]),
    .r_req(r_req[1]), .r_addr(r_addr[1]), .r_busy(r_busy[1]), .r_rdy(r_rdy[1]), .r_data(r_data[1]),
    .w_req(w_req[1]), .w_addr(w_addr[1]), .w_data(w_data[1]), .w_be(w_be[1]),
    .w_busy(w_busy[1]), .w_rdy(w_rdy[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [15:0] lane_merge(input logic [15:0] o, input logic [15:0] n, input logic [1:0] be);
    logic [15:0] m;
    m = {{8{be[1]}}, {8{be[0]}}};
    return (o & ~m) | (n & m);
  endfunction

  function automatic logic [15:0] expect_read(input int d, input int a);
    return a < qty[d] ? model[d][a] : ini[d];
  endfunction

  task automatic model_init(input int d);
    for (int a = 0; a < 16; a++) model[d][a] = ini[d];
  endtask

  task automatic wait_rdy(input int d, input bit w, output int at);
    at = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (w ? w_rdy[d] : r_rdy[d]) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) chk(w ? "w_rdy_timeout" : "r_rdy_timeout", 0, 1);
  endtask

  task automatic do_write(input int d, input int a, input logic [15:0] data, input logic [1:0] be);
    int acc, at;
    w_req[d] = 1'b1; w_addr[d] = 4'(a); w_data[d] = data; w_be[d] = be;
    @(negedge clock);
    w_req[d] = 1'b0;
    acc = cyc;
    chk("w_busy", w_busy[d], 1);
    wait_rdy(d, 1'b1, at);
    chk("w_latency", at - acc, ww[d] + 1);
    if (a < qty[d]) model[d][a] = lane_merge(model[d][a], data, be);
  endtask

  task automatic do_read(input int d, input int a);
    int acc, at;
    r_req[d] = 1'b1; r_addr[d] = 4'(a);
    @(negedge clock);
    r_req[d] = 1'b0;
    acc = cyc;
    chk("r_busy", r_busy[d], 1);
    wait_rdy(d, 1'b0, at);
    chk("r_latency", at - acc, rw[d] + 1);
    chk("r_data", r_data[d], expect_read(d, a));
  endtask

  task automatic collide(input int d, input int a, input logic [15:0] data, input logic [1:0] be);
    int diff, at;
    logic [15:0] o;
    diff = ww[d] - rw[d];
    o = expect_read(d, a);
    w_req[d] = 1'b1; w_addr[d] = 4'(a); w_data[d] = data; w_be[d] = be;
    r_addr[d] = 4'(a); r_req[d] = diff == 0;
    @(negedge clock);
    w_req[d] = 1'b0; r_req[d] = 1'b0;
    for (int i = 1; i < diff; i++) @(negedge clock);
    if (diff > 0) begin
      r_req[d] = 1'b1;
      @(negedge clock);
      r_req[d] = 1'b0;
    end
    wait_rdy(d, 1'b1, at);
    chk("coll_same_cycle", r_rdy[d], 1);
    chk("coll_data", r_data[d], (rf[d] != 0 || a >= qty[d]) ? o : lane_merge(o, data, be));
    if (a < qty[d]) model[d][a] = lane_merge(model[d][a], data, be);
  endtask

  task automatic release_and_init();
    int c0, n;
    reset_n = 1'b1;
    c0 = cyc;
    model_init(0);
    model_init(1);
    for (int i = 0; i < 17; i++) begin
      @(negedge clock);
      n = cyc - c0;
      for (int d = 0; d < 2; d++) begin
        if (n == qty[d] - 1) chk("init_pending", init_done[d], 0);
        if (n == qty[d]) chk("init_done", init_done[d], 1);
      end
    end
  endtask

  initial begin
    int cs, rdy_seen;
    for (int d = 0; d < 2; d++) begin
      init_start[d] = 0; r_req[d] = 0; w_req[d] = 0;
      r_addr[d] = 0; w_addr[d] = 0; w_data[d] = 0; w_be[d] = 0;
    end
    repeat (3) @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      chk("rst_init_done", init_done[d], 0);
      chk("rst_busy", {r_busy[d], w_busy[d]}, 0);
      chk("rst_rdy", {r_rdy[d], w_rdy[d]}, 0);
      chk("rst_r_data", r_data[d], 0);
    end
    release_and_init();
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 16; a++) do_read(d, a);
    do_write(0, 3, 16'hA5C3, 2'b11);
    do_read(0, 3);
    chk("readback_a5c3", r_data[0], 16'hA5C3);
    do_write(0, 3, 16'hFFFF, 2'b01);
    do_read(0, 3);
    chk("lane_a5ff", r_data[0], 16'hA5FF);
    do_write(0, 5, 16'h1111, 2'b11);
    collide(0, 5, 16'hABCD, 2'b10);
    chk("coll_new", r_data[0], 16'hAB11);
    do_write(1, 5, 16'h2222, 2'b11);
    collide(1, 5, 16'hABCD, 2'b11);
    chk("coll_old", r_data[1], 16'h2222);
    do_read(1, 5);
    do_write(1, 13, 16'hDEAD, 2'b11);
    do_read(1, 13);
    do_write(0, 6, 16'h0F0F, 2'b00);
    do_read(0, 6);
    for (int i = 0; i < 80; i++) begin
      int d, a, op;
      d = $urandom_range(0, 1);
      a = $urandom_range(0, 15);
      op = $urandom_range(0, 2);
      if (op == 0) do_write(d, a, 16'($urandom), 2'($urandom));
      else if (op == 1) do_read(d, a);
      else collide(d, a, 16'($urandom), 2'($urandom));
    end
    do_write(0, 7, 16'h7777, 2'b11);
    do_read(0, 7);
    r_req[0] = 1'b1; r_addr[0] = 4'd2;
    @(negedge clock);
    r_req[0] = 1'b0;
    chk("abort_busy_before", r_busy[0], 1);
    init_start[0] = 1'b1;
    @(negedge clock);
    init_start[0] = 1'b0;
    cs = cyc;
    chk("abort_busy", r_busy[0], 0);
    chk("abort_rdy", r_rdy[0], 0);
    chk("abort_r_data", r_data[0], 16'h7777);
    chk("abort_init_done", init_done[0], 0);
    model_init(0);
    rdy_seen = 0;
    while (cyc - cs < 16) begin
      @(negedge clock);
      if (r_rdy[0]) rdy_seen++;
      if (cyc - cs == 15) chk("resweep_pending", init_done[0], 0);
    end
    chk("resweep_done", init_done[0], 1);
    chk("abort_no_rdy", rdy_seen, 0);
    do_read(0, 7);
    do_write(0, 9, 16'hBEEF, 2'b11);
    do_read(0, 9);
    w_req[0] = 1'b1; w_addr[0] = 4'd4; w_data[0] = 16'h4444; w_be[0] = 2'b11;
    @(negedge clock);
    w_req[0] = 1'b0;
    chk("mid_w_busy", w_busy[0], 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_w_busy", w_busy[0], 0);
    chk("async_init_done", init_done[0], 0);
    chk("async_r_data", r_data[0], 0);
    chk("async_rdy", {r_rdy[0], w_rdy[0], r_busy[0]}, 0);
    rdy_seen = 0;
    repeat (4) begin
      @(negedge clock);
      if (w_rdy[0]) rdy_seen++;
    end
    chk("reset_no_w_rdy", rdy_seen, 0);
    release_and_init();
    do_read(0, 4);
    do_read(0, 9);
    do_read(1, 5);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
